// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle for fetch_queue
interface fetch_queue_if #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 2
);
   logic                      flush;
   logic [WIDTH-1:0]          in_valid;
   logic [WIDTH*32-1:0]       in_pc;
   logic [WIDTH*32-1:0]       in_instr;
   logic                      in_ready;
   logic [WIDTH-1:0]          out_valid;
   logic [WIDTH*32-1:0]       out_pc;
   logic [WIDTH*32-1:0]       out_instr;
   logic                      out_ready;
   logic [$clog2(DEPTH):0]    count;

   modport master (
      output flush, in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, count
   );

   modport slave (
      input  flush, in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_instr, count
   );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular fetch-to-decode instruction queue
// Optional empty-queue bypass (0-cycle latency) enabled by FETCHQ_BYPASS_EN.
module fetch_queue #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 2
) (
   input logic           clk,
   input logic           resetn,
   fetch_queue_if.slave  q
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    head, tail;
   logic [CW-1:0]    cnt;
   logic [31:0]      ram_pc    [DEPTH];
   logic [31:0]      ram_instr [DEPTH];

   logic             ready;
   logic             legal;
   logic             push;
   logic             bypass_taken;
   logic [WIDTH-1:0] v_inc;
   logic [CW-1:0]    n_in;
   logic [CW-1:0]    n_wr;
   logic [CW-1:0]    n_pop;
`ifdef FETCHQ_BYPASS_EN
   logic             bypass;
`endif

   assign ready      = (CW'(DEPTH) - cnt) >= CW'(WIDTH);
   assign q.in_ready = ready;
   assign q.count    = cnt;

   // A legal valid mask is a run of ones from lane 0, i.e. v & (v+1) == 0.
   always_comb begin
      v_inc = q.in_valid + WIDTH'(1);
      legal = (q.in_valid & v_inc) == '0;
      n_in  = '0;
      for (int i = 0; i < WIDTH; i++)
         n_in = n_in + CW'(q.in_valid[i]);
      push  = ready && q.in_valid[0] && legal;
`ifdef FETCHQ_BYPASS_EN
      bypass       = (cnt == '0) && !q.flush;
      bypass_taken = bypass && q.out_ready && push;
`else
      bypass_taken = 1'b0;
`endif
      n_wr  = (push && !bypass_taken) ? n_in : '0;
      n_pop = q.out_ready ? ((cnt > CW'(WIDTH)) ? CW'(WIDTH) : cnt) : '0;
   end

   always_comb begin
      q.out_valid = '0;
      q.out_pc    = '0;
      q.out_instr = '0;
      for (int i = 0; i < WIDTH; i++) begin
         q.out_valid[i]        = cnt > CW'(i);
         q.out_pc[32*i +: 32]    = ram_pc[head + AW'(i)];
         q.out_instr[32*i +: 32] = ram_instr[head + AW'(i)];
      end
`ifdef FETCHQ_BYPASS_EN
      if (bypass) begin
         q.out_valid = q.in_valid & {WIDTH{ready}};
         q.out_pc    = q.in_pc;
         q.out_instr = q.in_instr;
      end
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (q.flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         tail <= tail + AW'(n_wr);
         head <= head + AW'(n_pop);
         cnt  <= cnt + n_wr - n_pop;
      end
   end

   // Entry storage needs no reset; lanes wrap naturally through the AW-bit index.
   always_ff @(posedge clk) begin
      if (push && !bypass_taken && !q.flush) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (q.in_valid[i]) begin
               ram_pc[tail + AW'(i)]    <= q.in_pc[32*i +: 32];
               ram_instr[tail + AW'(i)] <= q.in_instr[32*i +: 32];
            end
         end
      end
   end

   assert property (@(posedge clk) disable iff (!resetn) cnt <= CW'(DEPTH));
endmodule
